// File: rtl/dmem_seq.sv
// dmem_seq: sequences CPU byte/half/word loads and stores over a byte-wide data memory
module dmem_seq #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    typedef enum logic {IDLE, XFER} state_t;
    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d, last_q, last_d;
    logic wr_q, wr_d, uns_q, uns_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, res_q, res_d, rdata_q, rdata_d, merged;
    logic xfer, misal;
    assign xfer = state_q == XFER;
    assign misal = size == 2'b00 ? 1'b0 : size == 2'b01 ? addr[0] : |addr[1:0];
    assign merged = (res_q & ~(32'hFF << {cnt_q, 3'b000})) | ({24'h0, mem_rdata} << {cnt_q, 3'b000});
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        last_d = last_q;
        wr_d = wr_q;
        uns_d = uns_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        res_d = res_q;
        rdata_d = rdata_q;
        done_d = 1'b0;
        err_d = 1'b0;
        if (!xfer) begin
            if (req && misal) begin
                done_d = 1'b1;
                err_d = 1'b1;
            end else if (req) begin
                state_d = XFER;
                cnt_d = 2'd0;
                last_d = size == 2'b00 ? 2'd0 : size == 2'b01 ? 2'd1 : 2'd3;
                wr_d = wr;
                uns_d = uns;
                addr_d = addr;
                wdata_d = wdata;
            end
        end else begin
            cnt_d = cnt_q + 2'd1;
            res_d = wr_q ? res_q : merged;
            if (cnt_q == last_q) begin
                state_d = IDLE;
                done_d = 1'b1;
                rdata_d = wr_q ? rdata_q
                        : last_q == 2'd0 ? {{24{~uns_q & merged[7]}}, merged[7:0]}
                        : last_q == 2'd1 ? {{16{~uns_q & merged[15]}}, merged[15:0]}
                        : merged;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= 2'd0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            err_q <= err_d;
            rdata_q <= rdata_d;
        end
        last_q <= last_d;
        wr_q <= wr_d;
        uns_q <= uns_d;
        addr_q <= addr_d;
        wdata_q <= wdata_d;
        res_q <= res_d;
    end
    assign busy = xfer;
    assign done = done_q;
    assign err = err_q;
    assign rdata = rdata_q;
    assign mem_addr = addr_q + ADDR_W'(cnt_q);
    // strobes drop immediately on reset so an interrupted store writes nothing more
    assign mem_re = xfer & ~wr_q & ~rst;
    assign mem_we = xfer & wr_q & ~rst;
    assign mem_wdata = (xfer && wr_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_dmem_seq.sv
// tb_dmem_seq: random and directed checks of dmem_seq against a transaction-level model
module tb_dmem_seq;
    localparam int AW = 13;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0, uns = 1'b0;
    logic [1:0] size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0] wdata = 32'h0;
    logic busy, done, err, mem_re, mem_we;
    logic [31:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    bit [7:0] tb_mem [8192];
    bit [7:0] ref_mem [8192];
    int nvec = 0, nfail = 0;
    bit chk_en = 1'b0;
    logic poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [7:0] poke_d = 8'h00;
    bit m_busy = 0, m_wr = 0, m_done = 0, m_err = 0;
    int m_k = 0, m_n = 1;
    logic [AW-1:0] m_addr = '0;
    logic [31:0] m_wdata = 0, m_res = 0, m_rdata = 0;

    always #5 clk = ~clk;

    dmem_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (poke_en) tb_mem[poke_a] <= poke_d;
    end
    always @(negedge clk) if (mem_re) mem_rdata <= tb_mem[mem_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [AW-1:0] a, input int n, input bit u);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + AW'(i)];
        if (n == 1) return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (n == 2) return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // transaction model: whole load value fetched at acceptance, store bytes retired one per cycle
    always @(posedge clk) begin
        if (poke_en) ref_mem[poke_a] = poke_d;
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_rdata = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (m_busy) begin
                if (m_wr) ref_mem[m_addr + AW'(m_k)] = m_wdata[8*m_k +: 8];
                m_k++;
                if (m_k == m_n) begin
                    m_busy = 0; m_done = 1;
                    if (!m_wr) m_rdata = m_res;
                end
            end else if (req) begin
                m_n = nbytes(size);
                if ((m_n == 2 && addr[0]) || (m_n == 4 && addr[1:0] != 2'b00)) begin
                    m_done = 1; m_err = 1;
                end else begin
                    m_busy = 1; m_k = 0; m_wr = wr; m_addr = addr; m_wdata = wdata;
                    if (!wr) m_res = load_val(addr, m_n, uns);
                end
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        logic [AW-1:0] ea;
        ea = m_addr + AW'(m_k);
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("rdata", rdata, m_rdata);
        check("mem_re", 32'(mem_re), 32'(m_busy && !m_wr && !rst));
        check("mem_we", 32'(mem_we), 32'(m_busy && m_wr && !rst));
        if (m_busy) check("mem_addr", 32'(mem_addr), 32'(ea));
        if (!m_busy) check("mem_wdata_idle", 32'(mem_wdata), 32'h0);
        else if (m_wr) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata[8*m_k +: 8]));
    end

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        @(posedge clk); #1 poke_en = 1'b0;
    endtask

    task automatic op(input bit w, input logic [1:0] s, input bit u, input logic [AW-1:0] a,
                      input logic [31:0] d, output int lat, output bit e, output logic [31:0] rd);
        req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk); #1 req = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        e = err; rd = rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, seen, bad;
        bit e;
        logic [31:0] rd;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        op(1'b1, 2'b10, 1'b0, AW'(16'h0100), 32'hDEADBEEF, lat, e, rd);
        check("wst_lat", 32'(lat), 32'd5);
        check("wst_err", 32'(e), 32'h0);
        check("wst_b0", 32'(tb_mem[13'h100]), 32'hEF);
        check("wst_b1", 32'(tb_mem[13'h101]), 32'hBE);
        check("wst_b2", 32'(tb_mem[13'h102]), 32'hAD);
        check("wst_b3", 32'(tb_mem[13'h103]), 32'hDE);
        poke(AW'(16'h0200), 8'h80);
        op(1'b0, 2'b00, 1'b0, AW'(16'h0200), 32'h0, lat, e, rd);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_sext", rd, 32'hFFFFFF80);
        op(1'b0, 2'b00, 1'b1, AW'(16'h0200), 32'h0, lat, e, rd);
        check("lbu_zext", rd, 32'h00000080);
        op(1'b0, 2'b01, 1'b0, AW'(16'h0101), 32'h0, lat, e, rd);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(e), 32'h1);
        check("mis_rdata", rd, 32'h00000080);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = AW'(16'h0300); wdata = 32'h44332211;
        @(posedge clk); #1 req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; req = 1'b1; wr = 1'b1; size = 2'b00; addr = AW'(16'h0007); wdata = 32'h99;
        seen = 0;
        @(negedge clk); seen += int'(done);
        @(posedge clk); #1 rst = 1'b0; req = 1'b0;
        repeat (6) begin @(negedge clk); seen += int'(done); end
        @(posedge clk); #1;
        check("rst_nodone", 32'(seen), 32'h0);
        check("rst_idle", 32'(busy), 32'h0);
        check("rst_b0", 32'(tb_mem[13'h300]), 32'h11);
        check("rst_b1", 32'(tb_mem[13'h301]), 32'h22);
        check("rst_b2", 32'(tb_mem[13'h302]), 32'h00);
        check("rst_b3", 32'(tb_mem[13'h303]), 32'h00);
        check("rst_req_drop", 32'(tb_mem[13'h007]), 32'h00);
        poke(AW'(16'h0400), 8'h01); poke(AW'(16'h0401), 8'h02);
        poke(AW'(16'h0402), 8'h03); poke(AW'(16'h0403), 8'h04);
        req = 1'b1; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = AW'(16'h0400);
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1 req = 1'b1; wr = 1'b1; size = 2'b00; addr = AW'(16'h0500); wdata = 32'h5A;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_rdata", rdata, 32'h04030201);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        check("b2b_we", 32'(mem_we), 32'h1);
        check("b2b_addr", 32'(mem_addr), 32'h500);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'h1);
        @(posedge clk); #1;
        check("b2b_mem", 32'(tb_mem[13'h500]), 32'h5A);
        for (int c = 0; c < 3000; c++) begin
            req = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? AW'(13'h1FF0 + 13'($urandom_range(0, 15)))
                                               : AW'($urandom_range(0, 63));
            wdata = $urandom;
            rst = ($urandom_range(0, 149) == 0);
            @(posedge clk); #1;
        end
        req = 1'b0; rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 bad = 0;
        for (int i = 0; i < 8192; i++) if (tb_mem[i] != ref_mem[i]) bad++;
        check("mem_image", 32'(bad), 32'h0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
